// File: rtl/matrix_operand_loader_pkg.sv
// rtl/matrix_operand_loader_pkg.sv - shared types, defaults and index helper for the operand loader
package matrix_operand_loader_pkg;

  localparam int OP_WIDTH_DEFAULT  = 8;
  localparam int ACC_WIDTH_DEFAULT = 32;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  typedef enum logic [1:0] {
    LOAD_A = ST_LOAD_A,
    LOAD_B = ST_LOAD_B,
    ISSUE  = ST_ISSUE,
    WAIT   = ST_WAIT
  } loader_state_t;

  // Row-major flat index of element (r,c) in an n x n matrix; the multiplier
  // unpacks its operand buses with the same mapping.
  function automatic int unsigned elem_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// rtl/matrix_operand_loader_if.sv - serial operand element stream into the loader
interface matrix_operand_loader_if
  import matrix_operand_loader_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEFAULT
);

  logic                in_valid;
  logic                in_ready;
  logic [OP_WIDTH-1:0] in_data;
  logic                in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/matrix_operand_loader.sv
// rtl/matrix_operand_loader.sv - packs a serial A/B element stream into operand buses and starts the multiplier
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
#(
  parameter int N        = 2,
  parameter int OP_WIDTH = OP_WIDTH_DEFAULT
)
(
  input  logic                     clk,
  input  logic                     reset,
  matrix_operand_loader_if.slave   in_s,
  output logic [N*N*OP_WIDTH-1:0]  mat_a,
  output logic [N*N*OP_WIDTH-1:0]  mat_b,
  output logic                     start,
  input  logic                     mult_done,
  output logic                     busy,
  output logic                     err,
  input  logic                     err_clear
);

  localparam int NN    = N * N;
  localparam int CNT_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NN - 1);

  loader_state_t           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NN*OP_WIDTH-1:0]  mat_a_q, mat_a_d;
  logic [NN*OP_WIDTH-1:0]  mat_b_q, mat_b_d;
  logic                    err_q, err_d;
  logic                    live_q;
  logic                    accept;
  logic                    at_last;
  logic                    frame_err;

  // Holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  assign in_s.in_ready = live_q && ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign accept        = in_s.in_valid && in_s.in_ready;
  assign at_last       = (cnt_q == CNT_LAST);

  // Next-state: element placement, pair framing and the start/wait handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mat_a_d   = mat_a_q;
    mat_b_d   = mat_b_q;
    frame_err = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (accept) begin
          mat_a_d[OP_WIDTH*cnt_q +: OP_WIDTH] = in_s.in_data;
          if (in_s.in_last) begin
            // in_last can only mark the final B element.
            frame_err = 1'b1;
            cnt_d     = '0;
          end else if (at_last) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          mat_b_d[OP_WIDTH*cnt_q +: OP_WIDTH] = in_s.in_data;
          if (at_last) begin
            cnt_d = '0;
            if (in_s.in_last) begin
              state_d = ISSUE;
            end else begin
              // Pair ended without its marker: drop it, no start.
              frame_err = 1'b1;
              state_d   = LOAD_A;
            end
          end else if (in_s.in_last) begin
            frame_err = 1'b1;
            cnt_d     = '0;
            state_d   = LOAD_A;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mult_done) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky error flag; a new framing error takes priority over a clear.
  always_comb begin
    err_d = err_q;
    if (frame_err) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end
  end

  // State, counter, operand buffers and error register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      err_q   <= err_d;
    end
  end

  assign mat_a = mat_a_q;
  assign mat_b = mat_b_q;
  assign start = (state_q == ISSUE);
  assign busy  = (state_q == ISSUE) || (state_q == WAIT);
  assign err   = err_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb/tb_matrix_operand_loader.sv - self-checking bench for matrix_operand_loader
module tb_matrix_operand_loader;
  import matrix_operand_loader_pkg::*;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int NN = N * N;

  logic clk = 1'b0;
  logic reset;
  logic [NN*W-1:0] mat_a, mat_b;
  logic start, mult_done, busy, err, err_clear;

  matrix_operand_loader_if #(.OP_WIDTH(W)) in_if ();

  matrix_operand_loader #(.N(N), .OP_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_s      (in_if),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .start     (start),
    .mult_done (mult_done),
    .busy      (busy),
    .err       (err),
    .err_clear (err_clear)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_pass    = 0;
  int start_cnt = 0;

  logic [W-1:0] a_el [NN];
  logic [W-1:0] b_el [NN];

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Expected bus: element (r,c) at bit offset W*(r*N+c).
  function automatic logic [NN*W-1:0] pack_a();
    logic [NN*W-1:0] v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[W*elem_idx(r, c, N) +: W] = a_el[elem_idx(r, c, N)];
    return v;
  endfunction

  function automatic logic [NN*W-1:0] pack_b();
    logic [NN*W-1:0] v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[W*elem_idx(r, c, N) +: W] = b_el[elem_idx(r, c, N)];
    return v;
  endfunction

  // Offers one element and returns #1 after the edge that accepted it.
  task automatic send(input logic [W-1:0] d, input logic l);
    logic r;
    int   k;
    in_if.in_valid = 1'b1;
    in_if.in_data  = d;
    in_if.in_last  = l;
    r = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      r = in_if.in_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    if (!r) begin
      n_checks++;
      $display("FAIL send_timeout: data %0h never accepted within 40 cycles", d);
    end
  endtask

  task automatic send_pair(input int gap);
    for (int i = 0; i < 2*NN; i++) begin
      if (i < NN) send(a_el[i], 1'b0);
      else        send(b_el[i-NN], (i == 2*NN-1));
      if (i != 2*NN-1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic finish_mult();
    mult_done = 1'b1;
    @(posedge clk); #1;
    mult_done = 1'b0;
  endtask

  task automatic apply_reset();
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_last  = 1'b0;
    mult_done = 1'b0;
    err_clear = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_last  = 1'b0;
    mult_done = 1'b0;
    err_clear = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_if.in_ready, start, busy, err} !== 4'b0) $display("FAIL reset_ctrl: ready/start/busy/err=%b required 0000", {in_if.in_ready, start, busy, err});
    else n_pass++;
    n_checks++;
    if ({mat_a, mat_b} !== '0) $display("FAIL reset_mats: a=%h b=%h required 0", mat_a, mat_b);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (in_if.in_ready !== 1'b0) $display("FAIL reset_release_ready: %b required 0 before first edge", in_if.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (in_if.in_ready !== 1'b1) $display("FAIL reset_ready_rise: %b required 1", in_if.in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int sc;
    for (int i = 0; i < NN; i++) begin a_el[i] = W'(i + 1); b_el[i] = W'(i + 5); end
    sc = start_cnt;
    send_pair(0);
    n_checks++;
    if (start !== 1'b1) $display("FAIL b2b_start: %b required 1 after final accept", start);
    else n_pass++;
    n_checks++;
    if (mat_a !== 32'h04030201 || mat_b !== 32'h08070605) $display("FAIL b2b_mats: a=%h b=%h required 04030201 08070605", mat_a, mat_b);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || in_if.in_ready !== 1'b0) $display("FAIL b2b_busy: busy=%b ready=%b required 1 0", busy, in_if.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (start !== 1'b0 || busy !== 1'b1 || start_cnt != sc + 1) $display("FAIL b2b_wait: start=%b busy=%b pulses=%0d required 0 1 1", start, busy, start_cnt - sc);
    else n_pass++;
    finish_mult();
    n_checks++;
    if (busy !== 1'b0 || in_if.in_ready !== 1'b1) $display("FAIL b2b_done: busy=%b ready=%b required 0 1", busy, in_if.in_ready);
    else n_pass++;
  endtask

  task automatic test_toggle_valid();
    int sc;
    for (int i = 0; i < NN; i++) begin a_el[i] = W'(i + 1); b_el[i] = W'(i + 5); end
    sc = start_cnt;
    send_pair(1);
    n_checks++;
    if (start !== 1'b1 || mat_a !== pack_a() || mat_b !== pack_b()) $display("FAIL toggle_issue: start=%b a=%h b=%h required 1 %h %h", start, mat_a, mat_b, pack_a(), pack_b());
    else n_pass++;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if (start_cnt != sc + 1) $display("FAIL toggle_pulses: %0d start pulses required 1", start_cnt - sc);
    else n_pass++;
    finish_mult();
  endtask

  task automatic test_wait_hold();
    int bad_ready, bad_mats;
    logic [NN*W-1:0] ea, eb;
    for (int i = 0; i < NN; i++) begin a_el[i] = W'($urandom); b_el[i] = W'($urandom); end
    ea = pack_a();
    eb = pack_b();
    send_pair(0);
    @(posedge clk); #1;
    bad_ready = 0;
    bad_mats  = 0;
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'd9;
    in_if.in_last  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (in_if.in_ready !== 1'b0) bad_ready++;
      if (mat_a !== ea || mat_b !== eb) bad_mats++;
    end
    n_checks++;
    if (bad_ready != 0) $display("FAIL wait_ready: in_ready high in %0d of 10 cycles required 0", bad_ready);
    else n_pass++;
    n_checks++;
    if (bad_mats != 0) $display("FAIL wait_hold: buses changed in %0d of 10 cycles required 0", bad_mats);
    else n_pass++;
    @(posedge clk); #1;
    finish_mult();
    n_checks++;
    if (in_if.in_ready !== 1'b1) $display("FAIL wait_release_ready: %b required 1", in_if.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_if.in_valid = 1'b0;
    n_checks++;
    if (mat_a[W-1:0] !== 8'd9 || mat_a[NN*W-1:W] !== ea[NN*W-1:W]) $display("FAIL wait_first_elem: a=%h required low byte 09 over %h", mat_a, ea);
    else n_pass++;
  endtask

  task automatic test_err_early_last();
    int sc;
    apply_reset();
    sc = start_cnt;
    send(8'd11, 1'b0);
    send(8'd12, 1'b0);
    send(8'd13, 1'b1);
    n_checks++;
    if (err !== 1'b1 || start !== 1'b0 || busy !== 1'b0) $display("FAIL early_last: err=%b start=%b busy=%b required 1 0 0", err, start, busy);
    else n_pass++;
    for (int i = 0; i < NN; i++) begin a_el[i] = W'($urandom); b_el[i] = W'($urandom); end
    send_pair(0);
    n_checks++;
    if (start !== 1'b1 || mat_a !== pack_a() || mat_b !== pack_b() || start_cnt != sc) $display("FAIL early_last_recover: start=%b a=%h b=%h prior pulses=%0d required 1 %h %h 0", start, mat_a, mat_b, start_cnt - sc, pack_a(), pack_b());
    else n_pass++;
    @(posedge clk); #1;
    finish_mult();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: %b required 1", err);
    else n_pass++;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_clear: %b required 0", err);
    else n_pass++;
    err_clear = 1'b1;
    send(8'd20, 1'b1);
    err_clear = 1'b0;
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_set_wins: %b required 1", err);
    else n_pass++;
  endtask

  task automatic test_err_no_last();
    int sc;
    apply_reset();
    sc = start_cnt;
    for (int i = 0; i < 2*NN; i++) send(W'(8'h30 + i), 1'b0);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_if.in_ready !== 1'b1) $display("FAIL no_last: err=%b busy=%b ready=%b required 1 0 1", err, busy, in_if.in_ready);
    else n_pass++;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (start_cnt != sc) $display("FAIL no_last_start: %0d pulses required 0", start_cnt - sc);
    else n_pass++;
    send(8'h5A, 1'b0);
    n_checks++;
    if (mat_a[W-1:0] !== 8'h5A) $display("FAIL no_last_reload: a[0]=%h required 5a", mat_a[W-1:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int sc;
    apply_reset();
    for (int i = 0; i < 6; i++) send(W'(i + 1), 1'b0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({mat_a, mat_b} !== '0 || {in_if.in_ready, start, busy, err} !== 4'b0) $display("FAIL mid_reset: a=%h b=%h ctl=%b required all 0", mat_a, mat_b, {in_if.in_ready, start, busy, err});
    else n_pass++;
    sc = start_cnt;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (start !== 1'b0 || start_cnt != sc || in_if.in_ready !== 1'b1) $display("FAIL mid_reset_release: start=%b pulses=%0d ready=%b required 0 0 1", start, start_cnt - sc, in_if.in_ready);
    else n_pass++;
    for (int i = 0; i < NN; i++) begin a_el[i] = W'($urandom); b_el[i] = W'($urandom); end
    send_pair(0);
    n_checks++;
    if (start !== 1'b1 || mat_a !== pack_a() || mat_b !== pack_b()) $display("FAIL mid_reset_stream: start=%b a=%h b=%h required 1 %h %h", start, mat_a, mat_b, pack_a(), pack_b());
    else n_pass++;
    @(posedge clk); #1;
    finish_mult();
  endtask

  task automatic test_random();
    int sc;
    int bad_busy;
    apply_reset();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NN; i++) begin a_el[i] = W'($urandom); b_el[i] = W'($urandom); end
      // A stray done while loading must be ignored.
      finish_mult();
      sc = start_cnt;
      send_pair(int'($urandom_range(0, 2)));
      n_checks++;
      if (start !== 1'b1 || mat_a !== pack_a() || mat_b !== pack_b()) $display("FAIL random_pair%0d: start=%b a=%h b=%h required 1 %h %h", it, start, mat_a, mat_b, pack_a(), pack_b());
      else n_pass++;
      bad_busy = 0;
      repeat ($urandom_range(1, 5)) begin
        @(posedge clk); #1;
        if (busy !== 1'b1 || mat_a !== pack_a() || mat_b !== pack_b()) bad_busy++;
      end
      n_checks++;
      if (bad_busy != 0 || start_cnt != sc + 1) $display("FAIL random_wait%0d: bad cycles=%0d pulses=%0d required 0 1", it, bad_busy, start_cnt - sc);
      else n_pass++;
      finish_mult();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_wait_hold();
    test_err_early_last();
    test_err_no_last();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
